// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and state encoding for the SPI flash responder
package spi_flash_pkg;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int         ADDR_W   = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } state_t;
endpackage

// File: rtl/spi_flash_resp_if.sv
// rtl/spi_flash_resp_if.sv - backing-store word fetch port of the SPI flash responder
interface spi_flash_resp_if;
    import spi_flash_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (output mem_req, mem_addr, input mem_rdata, mem_rvalid);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - SPI pin synchronizers with sck rise/fall and ss_n fall detection
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_n_s,
    output logic ss_fall,
    output logic mosi_s
);
    logic [SYNC_STAGES-1:0] sck_sr, ss_sr, mosi_sr;
    logic                   sck_s, sck_d, ss_d;

    // ss_n chain resets deasserted so leaving reset never fakes a select edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sr  <= '0;
            ss_sr   <= '1;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
            ss_d    <= 1'b1;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            ss_sr   <= {ss_sr[SYNC_STAGES-2:0], ss_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sck_d   <= sck_s;
            ss_d    <= ss_n_s;
        end
    end

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign ss_n_s   = ss_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ~ss_n_s & ss_d;
endmodule

// File: rtl/spi_flash_resp.sv
// rtl/spi_flash_resp.sv - SPI mode-0 READ responder streaming fetched words onto MISO
module spi_flash_resp #(
    parameter logic [7:0] CMD_READ    = spi_flash_pkg::CMD_READ,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             spi_sck,
    input  logic             spi_ss_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    spi_flash_resp_if.master mem,
    output logic             busy,
    output logic             underrun
);
    typedef spi_flash_pkg::state_t state_t;
    localparam int AW = spi_flash_pkg::ADDR_W;

    logic sck_rise, sck_fall, ss_n_s, ss_fall, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .sck      (spi_sck),
        .ss_n     (spi_ss_n),
        .mosi     (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_n_s   (ss_n_s),
        .ss_fall  (ss_fall),
        .mosi_s   (mosi_s)
    );

    state_t        state, next_state;
    logic [4:0]    bit_cnt;
    logic [6:0]    cmd_sr, data_sr;
    logic [AW-2:0] addr_sr;
    logic [7:0]    cmd_next, load_byte;
    logic [AW-1:0] addr_next, word_addr, pend_addr, issue_addr;
    logic [31:0]   word_buf, cur_word;
    logic [1:0]    byte_idx;
    logic          buf_valid, pend, req_stale;
    logic          addr_done, byte_load, bit_shift, advance, rvalid_ok, have_word, issue;

    assign cmd_next  = {cmd_sr, mosi_s};
    assign addr_next = {addr_sr, mosi_s};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= spi_flash_pkg::IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (ss_n_s) begin
            next_state = spi_flash_pkg::IDLE;
        end else begin
            case (state)
                spi_flash_pkg::IDLE:
                    if (ss_fall) next_state = spi_flash_pkg::CMD;
                spi_flash_pkg::CMD:
                    if (sck_rise && bit_cnt == 5'd7)
                        next_state = (cmd_next == CMD_READ) ? spi_flash_pkg::ADDR : spi_flash_pkg::IGNORE;
                spi_flash_pkg::ADDR:
                    if (sck_rise && bit_cnt == 5'd23) next_state = spi_flash_pkg::DATA;
                default: ;
            endcase
        end
    end

    // In DATA bit_cnt counts rises modulo 8, so a fall seen at zero starts a new byte
    always_comb begin
        busy       = (state != spi_flash_pkg::IDLE);
        addr_done  = !ss_n_s && state == spi_flash_pkg::ADDR && sck_rise && bit_cnt == 5'd23;
        byte_load  = !ss_n_s && state == spi_flash_pkg::DATA && sck_fall && bit_cnt == 5'd0;
        bit_shift  = !ss_n_s && state == spi_flash_pkg::DATA && sck_fall && bit_cnt != 5'd0;
        advance    = byte_load && byte_idx == 2'd3;
        rvalid_ok  = mem.mem_req && mem.mem_rvalid && !req_stale;
        cur_word   = rvalid_ok ? mem.mem_rdata : word_buf;
        have_word  = buf_valid || rvalid_ok;
        issue      = addr_done || advance;
        issue_addr = addr_done ? {addr_next[AW-1:2], 2'b00} : word_addr + AW'(4);
        load_byte  = cur_word[7:0];
        case (byte_idx)
            2'd1:    load_byte = cur_word[15:8];
            2'd2:    load_byte = cur_word[23:16];
            2'd3:    load_byte = cur_word[31:24];
            default: load_byte = cur_word[7:0];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            cmd_sr  <= '0;
            addr_sr <= '0;
        end else if (ss_n_s || state == spi_flash_pkg::IDLE) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            case (state)
                spi_flash_pkg::CMD: begin
                    cmd_sr  <= cmd_next[6:0];
                    bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                end
                spi_flash_pkg::ADDR: begin
                    addr_sr <= addr_next[AW-2:0];
                    bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                end
                spi_flash_pkg::DATA:
                    bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spi_miso <= 1'b0;
            data_sr  <= '0;
            underrun <= 1'b0;
            byte_idx <= '0;
        end else begin
            if (state == spi_flash_pkg::IDLE && ss_fall) underrun <= 1'b0;
            if (ss_n_s) begin
                spi_miso <= 1'b0;
            end else if (byte_load) begin
                data_sr  <= have_word ? load_byte[6:0] : 7'd0;
                spi_miso <= have_word & load_byte[7];
                if (!have_word) underrun <= 1'b1;
                byte_idx <= byte_idx + 2'd1;
            end else if (bit_shift) begin
                data_sr  <= {data_sr[5:0], 1'b0};
                spi_miso <= data_sr[6];
            end
            if (addr_done) byte_idx <= addr_next[1:0];
        end
    end

    // A request that is no longer wanted stays up until answered (req_stale drops its data);
    // a newer fetch waits in pend_addr and goes out as soon as that answer arrives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            word_buf     <= '0;
            buf_valid    <= 1'b0;
            word_addr    <= '0;
            pend         <= 1'b0;
            pend_addr    <= '0;
            req_stale    <= 1'b0;
        end else begin
            if (mem.mem_req && mem.mem_rvalid) begin
                mem.mem_req <= 1'b0;
                if (!req_stale) begin
                    word_buf  <= mem.mem_rdata;
                    buf_valid <= 1'b1;
                end
                if (pend && !ss_n_s) begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= pend_addr;
                    pend         <= 1'b0;
                    req_stale    <= 1'b0;
                end
            end
            if (ss_n_s) begin
                pend      <= 1'b0;
                req_stale <= 1'b1;
            end
            if (issue) begin
                buf_valid <= 1'b0;
                word_addr <= issue_addr;
                if (mem.mem_req && !mem.mem_rvalid) begin
                    pend      <= 1'b1;
                    pend_addr <= issue_addr;
                    req_stale <= 1'b1;
                end else begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= issue_addr;
                    req_stale    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_resp.sv
// tb/tb_spi_flash_resp.sv - scoreboard bench for spi_flash_resp with a byte-addressed memory model
module tb_spi_flash_resp;
    localparam int HALF = 12;

    logic clock = 1'b0;
    logic reset;
    logic spi_sck, spi_ss_n, spi_mosi, spi_miso, busy, underrun;

    spi_flash_resp_if mem_if ();

    spi_flash_resp dut (
        .clock    (clock),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_ss_n (spi_ss_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .mem      (mem_if),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_byte_q[$];
    logic [23:0] exp_fetch_q[$];
    int          lat = 1;
    bit          slow_once = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        if (a == 24'h000000) return 32'h44332211;
        if (a == 24'h000004) return 32'h88776655;
        return ({8'h00, a} * 32'h9E3779B1) ^ 32'hC001D00D;
    endfunction

    function automatic logic [7:0] byte_at(input logic [23:0] b);
        logic [31:0] w;
        w = mem_word({b[23:2], 2'b00});
        return w[8*b[1:0] +: 8];
    endfunction

    // memory: answers each new request after lat cycles and checks its address
    bit mbusy = 1'b0;
    int mcnt  = 0;
    always @(negedge clock) begin
        mem_if.mem_rvalid = 1'b0;
        if (reset) begin
            mbusy = 1'b0;
            mem_if.mem_rdata = 32'h0;
        end else if (mem_if.mem_req) begin
            if (!mbusy) begin
                mbusy = 1'b1;
                mcnt = slow_once ? 30 : lat;
                slow_once = 1'b0;
                if (exp_fetch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected: got addr %0h expected no fetch", mem_if.mem_addr);
                end else begin
                    chk("fetch_addr", 32'(mem_if.mem_addr), 32'(exp_fetch_q.pop_front()));
                end
            end
            if (mcnt <= 1) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = mem_word(mem_if.mem_addr);
                mbusy = 1'b0;
            end else begin
                mcnt--;
            end
        end
    end

    // miso monitor: bits after command+address are data bytes, MSB first, sampled on SCK rise
    int         mbits = 0;
    logic [7:0] mbyte = 8'h00;
    always @(posedge spi_sck or posedge spi_ss_n) begin
        if (spi_ss_n) begin
            mbits = 0;
        end else begin
            if (mbits >= 32) begin
                mbyte = {mbyte[6:0], spi_miso};
                if (mbits % 8 == 7) begin
                    if (exp_byte_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL miso_extra: got byte %0h expected none", mbyte);
                    end else begin
                        chk("miso_byte", 32'(mbyte), 32'(exp_byte_q.pop_front()));
                    end
                end
            end
            mbits++;
        end
    end

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b0;
        end
    endtask

    // The trailing SCK fall also loads one more byte, so n data bytes mean n+1 loads
    task automatic xact(input logic [7:0] cmd, input logic [23:0] a, input int n, input bit slow);
        logic [23:0] b;
        if (cmd == 8'h03) begin
            exp_fetch_q.push_back({a[23:2], 2'b00});
            for (int k = 0; k <= n; k++) begin
                b = a + 24'(k);
                if (k < n) exp_byte_q.push_back((slow && k == 0) ? 8'h00 : byte_at(b));
                if (b[1:0] == 2'd3) exp_fetch_q.push_back({b[23:2], 2'b00} + 24'd4);
            end
        end else begin
            for (int k = 0; k < n; k++) exp_byte_q.push_back(8'h00);
        end
        slow_once = slow;
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
        chk("underrun_cleared", 32'(underrun), 32'd0);
        spi_byte(cmd);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
        for (int k = 0; k < n; k++) spi_byte(8'($urandom));
        repeat (HALF) @(negedge clock);
        chk("busy_active", 32'(busy), 32'd1);
        spi_ss_n = 1'b1;
        repeat (3 * HALF) @(negedge clock);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("miso_idle", 32'(spi_miso), 32'd0);
        chk("underrun_flag", 32'(underrun), 32'(slow && cmd == 8'h03));
        chk("bytes_left", 32'(exp_byte_q.size()), 32'd0);
        chk("fetches_left", 32'(exp_fetch_q.size()), 32'd0);
        exp_byte_q.delete();
        exp_fetch_q.delete();
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [23:0] a;
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        lat = 1;
        xact(8'h03, 24'h000000, 4, 1'b0);
        xact(8'h03, 24'h000002, 4, 1'b0);
        xact(8'h9F, 24'h123456, 1, 1'b0);
        xact(8'h03, 24'hFFFFFC, 5, 1'b0);
        xact(8'h03, 24'h000000, 4, 1'b1);
        xact(8'h03, 24'h000001, 2, 1'b0);

        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
        spi_byte(8'h03);
        spi_byte(8'h12);
        #2 reset = 1'b1;
        #1;
        chk("arst_miso", 32'(spi_miso), 32'd0);
        chk("arst_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        spi_ss_n = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (3 * HALF) @(negedge clock);
        xact(8'h03, 24'h000004, 3, 1'b0);

        for (int t = 0; t < 10; t++) begin
            lat = $urandom_range(1, 3);
            cmd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03;
            if (t == 0 && cmd == 8'h03) cmd = 8'hAB;
            a = ($urandom_range(0, 1) == 0) ? 24'hFFFFF8 + 24'($urandom_range(0, 7)) : 24'($urandom);
            xact(cmd, a, $urandom_range(1, 6), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
